// File: rtl/branch_sequencer.sv
// Sequences one short conditional branch / LOOP-family / JCXZ op: pre-decrements
// the count, consults the external condition evaluator and redirects fetch if taken.
module branch_sequencer #(
  parameter int unsigned EIP_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [7:0]       ir_i,
  input  logic             big_i,
  input  logic [EIP_W-1:0] disp_i,
  input  logic [EIP_W-1:0] eip_i,
  input  logic [EIP_W-1:0] ecx_i,
  input  logic [4:0]       flags_i,
  output logic [7:0]       eb_ir_o,
  output logic             eb_big_o,
  output logic [EIP_W-1:0] eb_ecx_o,
  output logic [4:0]       eb_flags_o,
  input  logic             eb_take_i,
  output logic             ecx_we_o,
  output logic [EIP_W-1:0] ecx_o,
  output logic             redir_req_o,
  output logic [EIP_W-1:0] redir_eip_o,
  input  logic             redir_ack_i,
  input  logic             flush_i,
  output logic             done_o,
  output logic             taken_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    EVAL  = 2'd2,
    REDIR = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0]       ir;
  logic             big;
  logic [EIP_W-1:0] disp;
  logic [EIP_W-1:0] eip;
  logic [EIP_W-1:0] ecx;
  logic [4:0]       flags;

  logic             is_loop;
  logic             accept;
  logic [EIP_W-1:0] cnt;
  logic [EIP_W-1:0] target;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;

  // Count and target datapath; 16-bit forms keep upper ECX and clear upper IP.
  always_comb begin
    is_loop = (ir == 8'hE0) || (ir == 8'hE1) || (ir == 8'hE2);
    cnt     = ecx;
    if (is_loop) begin
      if (big) begin
        cnt = ecx - EIP_W'(1);
      end else begin
        cnt[15:0] = ecx[15:0] - 16'd1;
      end
    end
    target = eip + disp;
    if (!big) begin
      target[EIP_W-1:16] = '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = flush_i ? IDLE : EVAL;
      EVAL: begin
        if (flush_i)        state_next = IDLE;
        else if (eb_take_i) state_next = REDIR;
        else                state_next = IDLE;
      end
      REDIR: begin
        if (flush_i || redir_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir          <= '0;
      big         <= 1'b0;
      disp        <= '0;
      eip         <= '0;
      ecx         <= '0;
      flags       <= '0;
      eb_ir_o     <= '0;
      eb_big_o    <= 1'b0;
      eb_ecx_o    <= '0;
      eb_flags_o  <= '0;
      ecx_we_o    <= 1'b0;
      ecx_o       <= '0;
      redir_req_o <= 1'b0;
      redir_eip_o <= '0;
      done_o      <= 1'b0;
      taken_o     <= 1'b0;
    end else begin
      ecx_we_o <= 1'b0;
      done_o   <= 1'b0;
      taken_o  <= 1'b0;
      case (state)
        IDLE: begin
          redir_req_o <= 1'b0;
          if (accept) begin
            ir    <= ir_i;
            big   <= big_i;
            disp  <= disp_i;
            eip   <= eip_i;
            ecx   <= ecx_i;
            flags <= flags_i;
          end
        end
        CALC: begin
          if (!flush_i) begin
            eb_ir_o     <= ir;
            eb_big_o    <= big;
            eb_ecx_o    <= cnt;
            eb_flags_o  <= flags;
            ecx_we_o    <= is_loop;
            ecx_o       <= cnt;
            redir_eip_o <= target;
          end
        end
        EVAL: begin
          if (!flush_i) begin
            if (eb_take_i) redir_req_o <= 1'b1;
            else           done_o      <= 1'b1;
          end
        end
        REDIR: begin
          // Flush wins over a same-cycle ack: request drops with no completion.
          if (flush_i) begin
            redir_req_o <= 1'b0;
          end else if (redir_ack_i) begin
            redir_req_o <= 1'b0;
            done_o      <= 1'b1;
            taken_o     <= 1'b1;
          end
        end
        default: redir_req_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a behavioural branch-condition evaluator.
module tb_branch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  ir_i;
  logic        big_i;
  logic [31:0] disp_i;
  logic [31:0] eip_i;
  logic [31:0] ecx_i;
  logic [4:0]  flags_i;
  logic [7:0]  eb_ir_o;
  logic        eb_big_o;
  logic [31:0] eb_ecx_o;
  logic [4:0]  eb_flags_o;
  logic        eb_take_i;
  logic        ecx_we_o;
  logic [31:0] ecx_o;
  logic        redir_req_o;
  logic [31:0] redir_eip_o;
  logic        redir_ack_i;
  logic        flush_i;
  logic        done_o;
  logic        taken_o;

  int n_cmp = 0;
  int n_bad = 0;

  branch_sequencer #(.EIP_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .ir_i(ir_i), .big_i(big_i), .disp_i(disp_i), .eip_i(eip_i), .ecx_i(ecx_i),
    .flags_i(flags_i), .eb_ir_o(eb_ir_o), .eb_big_o(eb_big_o), .eb_ecx_o(eb_ecx_o),
    .eb_flags_o(eb_flags_o), .eb_take_i(eb_take_i), .ecx_we_o(ecx_we_o), .ecx_o(ecx_o),
    .redir_req_o(redir_req_o), .redir_eip_o(redir_eip_o), .redir_ack_i(redir_ack_i),
    .flush_i(flush_i), .done_o(done_o), .taken_o(taken_o)
  );

  always #5 clk_i = ~clk_i;

  // Evaluator stand-in: flags are {vf,sf,zf,pf,cf}.
  logic cz, base;
  always_comb begin
    cz   = eb_big_o ? (eb_ecx_o == 32'd0) : (eb_ecx_o[15:0] == 16'd0);
    base = 1'b0;
    case (eb_ir_o[3:1])
      3'd0: base = eb_flags_o[4];
      3'd1: base = eb_flags_o[0];
      3'd2: base = eb_flags_o[2];
      3'd3: base = eb_flags_o[0] | eb_flags_o[2];
      3'd4: base = eb_flags_o[3];
      3'd5: base = eb_flags_o[1];
      3'd6: base = eb_flags_o[3] ^ eb_flags_o[4];
      default: base = eb_flags_o[2] | (eb_flags_o[3] ^ eb_flags_o[4]);
    endcase
    eb_take_i = 1'b0;
    if (eb_ir_o[7:4] == 4'h7) eb_take_i = base ^ eb_ir_o[0];
    else if (eb_ir_o == 8'hEB) eb_take_i = 1'b1;
    else if (eb_ir_o == 8'hE0) eb_take_i = ~cz & ~eb_flags_o[2];
    else if (eb_ir_o == 8'hE1) eb_take_i = ~cz & eb_flags_o[2];
    else if (eb_ir_o == 8'hE2) eb_take_i = ~cz;
    else if (eb_ir_o == 8'hE3) eb_take_i = cz;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // Present one op at a negedge; returns just after the accept edge.
  task automatic issue(input logic [7:0] ir, input logic big, input logic [31:0] disp,
                       input logic [31:0] eip, input logic [31:0] ecx, input logic [4:0] flags);
    ir_i = ir; big_i = big; disp_i = disp; eip_i = eip; ecx_i = ecx; flags_i = flags;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ir_i = '0; big_i = 1'b0; disp_i = '0; eip_i = '0;
    ecx_i = '0; flags_i = '0; redir_ack_i = 1'b0; flush_i = 1'b0;
    repeat (2) cyc();
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_req", redir_req_o, 0);
    check("rst_we", ecx_we_o, 0);
    check("rst_eip", redir_eip_o, 0);
    rst_ni = 1'b1;
    cyc();

    // JE not taken, 16-bit
    issue(8'h74, 1'b0, 32'h10, 32'h100, 32'd5, 5'b00000);
    cyc(); check("je_c1_ready", ready_o, 0); check("je_c1_we", ecx_we_o, 0);
    cyc(); check("je_c2_we", ecx_we_o, 0); check("je_c2_ir", eb_ir_o, 32'h74);
    check("je_c2_done", done_o, 0);
    cyc(); check("je_c3_done", done_o, 1); check("je_c3_taken", taken_o, 0);
    check("je_c3_req", redir_req_o, 0); check("je_c3_ready", ready_o, 1);
    cyc(); check("je_c4_done", done_o, 0);

    // LOOP 16-bit count wrap, taken
    issue(8'hE2, 1'b0, 32'hFFFFFFFE, 32'h00001000, 32'h12340000, 5'b0);
    cyc();
    cyc(); check("loop16_we", ecx_we_o, 1); check("loop16_ecx", ecx_o, 32'h1234FFFF);
    check("loop16_eb_ecx", eb_ecx_o, 32'h1234FFFF);
    cyc(); check("loop16_req", redir_req_o, 1); check("loop16_eip", redir_eip_o, 32'h00000FFE);
    check("loop16_we_once", ecx_we_o, 0); check("loop16_no_done", done_o, 0);
    redir_ack_i = 1'b1;
    cyc(); redir_ack_i = 1'b0;
    check("loop16_done", done_o, 1); check("loop16_taken", taken_o, 1);
    check("loop16_req_drop", redir_req_o, 0);

    // LOOP terminal count, 32-bit
    issue(8'hE2, 1'b1, 32'h20, 32'h5000, 32'd1, 5'b0);
    cyc();
    cyc(); check("loopt_we", ecx_we_o, 1); check("loopt_ecx", ecx_o, 0);
    cyc(); check("loopt_done", done_o, 1); check("loopt_taken", taken_o, 0);
    check("loopt_req", redir_req_o, 0);

    // JMP short, 16-bit IP wrap, ack in first REDIR cycle
    issue(8'hEB, 1'b0, 32'd4, 32'h0000FFFE, 32'h0, 5'b0);
    cyc();
    cyc(); check("jmp16_we", ecx_we_o, 0);
    cyc(); check("jmp16_req", redir_req_o, 1); check("jmp16_eip", redir_eip_o, 32'h00000002);
    redir_ack_i = 1'b1;
    cyc(); redir_ack_i = 1'b0;
    check("jmp16_done", done_o, 1); check("jmp16_taken", taken_o, 1);

    // JMP 32-bit backward, ack delayed
    issue(8'hEB, 1'b1, 32'hFFFFFFF0, 32'h00401000, 32'h0, 5'b0);
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      cyc(); check("jmp32_req_hold", redir_req_o, 1);
      check("jmp32_eip_hold", redir_eip_o, 32'h00400FF0); check("jmp32_no_done", done_o, 0);
    end
    cyc(); check("jmp32_req_ack", redir_req_o, 1);
    redir_ack_i = 1'b1;
    cyc(); redir_ack_i = 1'b0;
    check("jmp32_done", done_o, 1); check("jmp32_taken", taken_o, 1);
    check("jmp32_req_drop", redir_req_o, 0);

    // JCXZ 16-bit: low count zero -> taken, no write
    issue(8'hE3, 1'b0, 32'h10, 32'h200, 32'h00010000, 5'b0);
    cyc();
    cyc(); check("jcxz_we", ecx_we_o, 0); check("jcxz_eb_ecx", eb_ecx_o, 32'h00010000);
    cyc(); check("jcxz_req", redir_req_o, 1); check("jcxz_eip", redir_eip_o, 32'h210);
    redir_ack_i = 1'b1;
    cyc(); redir_ack_i = 1'b0;
    check("jcxz_done", done_o, 1);

    // Unsupported opcode completes not-taken
    issue(8'h90, 1'b1, 32'h10, 32'h200, 32'h7, 5'b11111);
    cyc();
    cyc(); check("unsup_we", ecx_we_o, 0);
    cyc(); check("unsup_done", done_o, 1); check("unsup_taken", taken_o, 0);

    // Flush with concurrent ack in REDIR
    issue(8'hEB, 1'b1, 32'h8, 32'h300, 32'h0, 5'b0);
    cyc(); cyc();
    cyc(); check("fl_req", redir_req_o, 1);
    redir_ack_i = 1'b1; flush_i = 1'b1;
    cyc(); redir_ack_i = 1'b0; flush_i = 1'b0;
    check("fl_done", done_o, 0); check("fl_req_drop", redir_req_o, 0); check("fl_ready", ready_o, 1);
    cyc(); check("fl_done2", done_o, 0);

    // Flush in IDLE blocks accept
    ir_i = 8'hEB; big_i = 1'b1; valid_i = 1'b1; flush_i = 1'b1;
    cyc(); valid_i = 1'b0; flush_i = 1'b0;
    check("fl_idle_ready", ready_o, 1);

    // Async reset mid-REDIR
    issue(8'hEB, 1'b1, 32'h8, 32'h400, 32'h0, 5'b0);
    cyc(); cyc();
    cyc(); check("rr_req", redir_req_o, 1);
    #2 rst_ni = 1'b0;
    #1 check("rr_req_drop", redir_req_o, 0); check("rr_ready", ready_o, 1);
    cyc(); rst_ni = 1'b1;
    cyc(); check("rr_done", done_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Sequences one short/near conditional branch, LOOP-family or JCXZ instruction from the decoder through to a fetch redirect. It pre-decrements ECX/CX for LOOP/LOOPZ/LOOPNZ and writes the new count back. It then presents the opcode, count and flags to the downstream combinational branch-condition evaluator and samples its take decision. If the branch is taken, it computes the target EIP and handshakes a redirect with the prefetch/fetch unit.

Parameters:
- EIP_W, 32, width of instruction pointer, displacement and ECX paths.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  decoder presents a branch op
- ready_o  out  1  block can accept; equals (state==IDLE)
- ir_i  in  8  opcode (70-7F, EB, E0-E3)
- big_i  in  1  1 = 32-bit operand/address size, 0 = 16-bit
- disp_i  in  EIP_W  sign-extended displacement
- eip_i  in  EIP_W  EIP of next sequential instruction
- ecx_i  in  EIP_W  current ECX
- flags_i  in  5  {vf,sf,zf,pf,cf}
- eb_ir_o  out  8  opcode to evaluator
- eb_big_o  out  1  size to evaluator
- eb_ecx_o  out  EIP_W  post-decrement count to evaluator
- eb_flags_o  out  5  flags to evaluator
- eb_take_i  in  1  evaluator decision (combinational from eb_* outputs)
- ecx_we_o  out  1  one-cycle ECX write strobe
- ecx_o  out  EIP_W  ECX write data
- redir_req_o  out  1  redirect request to fetch
- redir_eip_o  out  EIP_W  redirect target
- redir_ack_i  in  1  fetch accepts redirect
- flush_i  in  1  abandon current operation (exception/pipeline flush)
- done_o  out  1  one-cycle completion pulse
- taken_o  out  1  branch outcome, valid with done_o

Behaviour:
- Reset (rst_ni low, async): state=IDLE; all registered outputs 0. ready_o=1 because state is IDLE.
- States: IDLE -> CALC -> EVAL -> (REDIR) -> IDLE.
- IDLE: when valid_i is high, latch ir, big, disp, eip, ecx and flags, then go to CALC. The handshake is valid_i & ready_o; ready_o is low in every other state.
- CALC (1 cycle):
  - LOOP family (E0/E1/E2), big=1: cnt = ecx-1 mod 2^32.
  - LOOP family, big=0: cnt[15:0] = ecx[15:0]-1 mod 2^16, cnt[31:16] = ecx[31:16] unchanged.
  - LOOP family: pulse ecx_we_o with ecx_o=cnt.
  - All other opcodes: cnt=ecx, no write.
  - Register eb_ir_o, eb_big_o, eb_ecx_o=cnt and eb_flags_o; they stay stable through EVAL and REDIR.
  - Compute target = eip+disp; if big=0, target[31:16]=0 (16-bit IP wrap). Register into redir_eip_o.
- EVAL (1 cycle): sample eb_take_i.
  - 0: next cycle done_o=1, taken_o=0, go to IDLE.
  - 1: go to REDIR with redir_req_o=1.
- REDIR:
  - Hold redir_req_o and redir_eip_o stable until redir_ack_i is sampled high.
  - On ack: the next cycle drops redir_req_o, pulses done_o with taken_o=1, and returns to IDLE.
  - Ack may arrive in the first REDIR cycle.
- Latency, counted as cycles after the accept edge: not-taken done_o in cycle 3; taken redir_req_o in cycle 3; done_o one cycle after ack.
- Opcodes outside the supported set: the evaluator returns 0, so the op completes as not-taken with no ECX write.
- flush_i in CALC/EVAL/REDIR: return to IDLE next cycle, drop redir_req_o, no done_o. An ecx_we_o already pulsed is not undone. flush_i has priority over a same-cycle redir_ack_i. flush_i in IDLE blocks accept that cycle.
- Reset mid-operation: immediate IDLE; redir_req_o and ecx_we_o go low asynchronously.
- done_o and ecx_we_o are never high for more than 1 cycle. A new op can be accepted in the cycle after done_o.

Test Plan:
- Not taken JE, 16-bit: ir=74, zf=0, big=0. Required: no ecx_we_o; done_o in cycle 3 with taken_o=0; redir_req_o never asserted.
- LOOP 16-bit wrap: ir=E2, big=0, ecx=0x12340000. Required: ecx_we_o with ecx_o=0x1234FFFF; eb_ecx_o=0x1234FFFF; taken; redirect issued.
- LOOP terminal count: ir=E2, big=1, ecx=1. Required: ecx_o=0, not taken, done_o with taken_o=0.
- Taken 16-bit target wrap: ir=EB, big=0, eip=0x0000FFFE, disp=+4. Required: redir_eip_o=0x00000002.
- Taken 32-bit backward branch: eip=0x00401000, disp=0xFFFFFFF0. Required: redir_eip_o=0x00400FF0. With ack delayed 3 cycles, req and target stay stable, and done_o occurs the cycle after ack.
- flush_i asserted in REDIR concurrent with redir_ack_i. Required: no done_o, IDLE next cycle. Separately, rst_ni low mid-REDIR drops redir_req_o immediately, ready_o=1.
